fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the program counter and drives it to the PC+4 adder (adder input A; input B is tied to 32'd4 at top level). The adder's sum comes back to this block.
- Talks to instruction memory over a req/ready handshake with variable wait states.
- Absorbs hazard-unit stalls with a one-entry skid buffer, applies branch and jump redirects, and drives the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_o  out  32  current PC; goes to the PC+4 adder and to imem_addr
pc_plus4_i  in  32  adder result (pc_o + 4), combinational, same cycle
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; equals pc_o
imem_ready  in  1  response this cycle; imem_rdata is valid when ready=1
imem_rdata  in  32  instruction word
stall_if  in  1  hazard unit: hold IF/ID and stop PC advance
flush_if  in  1  squash the IF/ID contents (insert a bubble)
branch_taken  in  1  redirect request from the branch resolution stage
branch_target  in  32  branch target
jump  in  1  redirect request from decode
jump_target  in  32  jump target
ifid_instr  out  32  IF/ID instruction; 32'h0 (NOP) when squashed
ifid_pc_plus4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, asserted immediately), values of all state and outputs:
  - pc_reg=RESET_PC, state=BOOT, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, imem_req=0.
  - redirect_pend=0, pend_target=0, skid empty.
  - Reset asserted mid-transaction abandons it; the memory must tolerate a dropped req.
- Redirect target: branch_target if branch_taken, else jump_target. Branch has priority over jump (it comes from the older instruction). Target bits [1:0] are forced to 00. "Redirect" means branch_taken|jump.
- "Accept" means state==FETCH && imem_ready==1.
- FSM states: BOOT, FETCH, BUFFERED.
- BOOT:
  - imem_req=0; lasts exactly one cycle, then FETCH.
  - A redirect in BOOT loads pc_reg with the target.
- FETCH:
  - imem_req=1, imem_addr=pc_reg.
  - pc_reg must stay stable until accept; a redirect never changes the address of an outstanding request.
  - Accept, no redirect active or pending, stall_if=0: IF/ID <= {imem_rdata, pc_plus4_i, 1}; pc_reg <= pc_plus4_i.
  - Accept, no redirect active or pending, stall_if=1: skid <= {imem_rdata, pc_plus4_i}; pc_reg <= pc_plus4_i; IF/ID holds; go to BUFFERED.
  - Accept when a redirect is active this cycle or pending: discard imem_rdata; pc_reg <= target (this cycle's target wins over pend_target); clear redirect_pend; IF/ID gets a bubble unless stall_if.
  - No accept, redirect active: redirect_pend=1; pend_target <= target. A newer redirect overwrites an older pending one.
  - No accept, stall_if=0: ifid_valid <= 0 (bubble). No accept, stall_if=1: IF/ID holds.
- BUFFERED:
  - imem_req=0.
  - stall_if=0: IF/ID <= {skid, 1}; go to FETCH.
  - Redirect: discard skid; pc_reg <= target; go to FETCH. IF/ID takes a bubble if stall_if=0, else holds.
- flush_if: next cycle ifid_valid=0 and ifid_instr=0. Overrides stall_if and any IF/ID load in the same cycle. Does not by itself change pc_reg or the FSM state.
- Throughput: one instruction per cycle with zero-wait memory. Latency from accept to IF/ID visible is 1 clock.
- PC arithmetic is done only by the external adder. Wrap at 32'hFFFF_FFFC+4 -> 0 is natural and not flagged.

Test Plan:
1. Reset with RESET_PC=0x100, imem_ready tied 1 -> BOOT one cycle; imem_addr sequence 0x100, 0x104, 0x108; ifid_pc_plus4 0x104, 0x108, ... one cycle after each accept; ifid_valid=1 continuously.
2. imem_ready low 3 cycles at addr 0x104 -> imem_addr held at 0x104; ifid_valid=0 for those cycles; instruction lands in IF/ID the cycle after ready.
3. stall_if=1 during accept of 0x108 (word 0xAAAA0001), held 2 cycles -> imem_req=0 while BUFFERED; IF/ID unchanged; on release IF/ID={0xAAAA0001, 0x10C, 1}; next fetch at 0x10C.
4. branch_taken with target 0x200 and jump with target 0x300 in the same cycle, while waiting on 0x110 -> imem_addr stays 0x110 until ready; returned word discarded; next imem_addr 0x200; no 0x110 instruction ever reaches IF/ID.
5. flush_if and stall_if both high with IF/ID valid -> next cycle ifid_valid=0 and ifid_instr=0.
6. rst pulsed mid-wait (asynchronously, between clock edges) -> outputs reset immediately; imem_req=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined MIPS core. It owns the program
// counter, fetches from instruction memory over a req/ready handshake, and
// loads the IF/ID pipeline register. A one-entry skid buffer holds a word
// that returns while decode is stalled. Branch and jump redirects that arrive
// while a request is outstanding are remembered and applied once that
// request completes.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   pc_o              current PC, feeds the external PC+4 adder
//   pc_plus4_i        adder result (pc_o + 4), same cycle
//   imem_req/addr     fetch request and address (address is always pc_o)
//   imem_ready/rdata  memory response; rdata valid when ready=1
//   stall_if          hold IF/ID and stop PC advance
//   flush_if          squash IF/ID (valid=0, instr=NOP)
//   branch_taken/target, jump/jump_target   redirect requests (branch wins)
//   ifid_instr/pc_plus4/valid               IF/ID pipeline register
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_if,
  input  logic        flush_if,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    BUFFERED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        redirect_pend_q, redirect_pend_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_plus4_q, skid_pc_plus4_d;

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] redirect_target;
  logic        accept;

  // Branch comes from the older instruction, so it beats a same-cycle jump.
  assign redirect        = branch_taken | jump;
  assign raw_target      = branch_taken ? branch_target : jump_target;
  assign redirect_target = {raw_target[31:2], 2'b00};
  assign accept          = (state_q == FETCH) && imem_ready;

  assign pc_o      = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == FETCH);

  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;

  always_comb begin
    // NOTE: every signal gets a hold-value default up front so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    redirect_pend_d = redirect_pend_q;
    pend_target_d   = pend_target_q;
    skid_instr_d    = skid_instr_q;
    skid_pc_plus4_d = skid_pc_plus4_q;

    unique case (state_q)
      BOOT: begin
        if (redirect) pc_d = redirect_target;
        if (!stall_if) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end
        state_d = FETCH;
      end

      FETCH: begin
        if (accept) begin
          if (redirect || redirect_pend_q) begin
            // The returned word belongs to the wrong path; drop it. A
            // redirect seen this cycle is newer than the pending one.
            pc_d            = redirect ? redirect_target : pend_target_q;
            redirect_pend_d = 1'b0;
            if (!stall_if) begin
              ifid_valid_d = 1'b0;
              ifid_instr_d = '0;
            end
          end else if (!stall_if) begin
            ifid_instr_d    = imem_rdata;
            ifid_pc_plus4_d = pc_plus4_i;
            ifid_valid_d    = 1'b1;
            pc_d            = pc_plus4_i;
          end else begin
            skid_instr_d    = imem_rdata;
            skid_pc_plus4_d = pc_plus4_i;
            pc_d            = pc_plus4_i;
            state_d         = BUFFERED;
          end
        end else begin
          // Address must not move while the request is outstanding, so the
          // redirect is parked until the memory answers.
          if (redirect) begin
            redirect_pend_d = 1'b1;
            pend_target_d   = redirect_target;
          end
          if (!stall_if) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
          end
        end
      end

      BUFFERED: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = FETCH;
          if (!stall_if) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
          end
        end else if (!stall_if) begin
          ifid_instr_d    = skid_instr_q;
          ifid_pc_plus4_d = skid_pc_plus4_q;
          ifid_valid_d    = 1'b1;
          state_d         = FETCH;
        end
      end

      default: state_d = BOOT;
    endcase

    // Flush squashes IF/ID regardless of stall or any load chosen above.
    if (flush_if) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      ifid_instr_q    <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      redirect_pend_q <= 1'b0;
      pend_target_q   <= '0;
      skid_instr_q    <= '0;
      skid_pc_plus4_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      redirect_pend_q <= redirect_pend_d;
      pend_target_q   <= pend_target_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc_plus4_q <= skid_pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A behavioural model (queues for the
// skid word and the pending redirect) predicts PC, request and IF/ID after
// every clock. Directed sequences cover reset/boot, wait states, stall into
// the skid buffer, simultaneous branch+jump during a wait, flush over stall,
// and an asynchronous mid-cycle reset; a randomized run follows.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_if;
  logic        flush_if;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  // External PC+4 adder, as wired at the core top level.
  assign pc_plus4 = pc_o + 32'd4;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_o         (pc_o),
    .pc_plus4_i   (pc_plus4),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall_if     (stall_if),
    .flush_if     (flush_if),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } word_t;

  logic [31:0] m_pc;
  bit          m_booting;
  word_t       m_ifid;
  word_t       m_skid[$];   // at most one buffered word
  logic [31:0] m_pend[$];   // at most one parked redirect target

  function automatic void model_reset();
    m_pc      = RESET_PC;
    m_booting = 1'b1;
    m_ifid    = '{32'h0, 32'h0, 1'b0};
    m_skid.delete();
    m_pend.delete();
  endfunction

  function automatic void bubble();
    m_ifid.valid = 1'b0;
    m_ifid.instr = 32'h0;
  endfunction

  // Predicts the effect of one rising edge given the inputs now applied.
  function automatic void model_step();
    bit          redir;
    logic [31:0] tgt;
    word_t       w;
    redir = branch_taken | jump;
    tgt   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    if (m_booting) begin
      if (redir) m_pc = tgt;
      if (!stall_if) bubble();
      m_booting = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (redir) begin
        m_skid.delete();
        m_pc = tgt;
        if (!stall_if) bubble();
      end else if (!stall_if) begin
        m_ifid = m_skid.pop_front();
      end
    end else if (imem_ready) begin
      if (redir || m_pend.size() != 0) begin
        m_pc = redir ? tgt : m_pend[0];
        m_pend.delete();
        if (!stall_if) bubble();
      end else begin
        w = '{imem_rdata, m_pc + 32'd4, 1'b1};
        if (stall_if) m_skid.push_back(w);
        else          m_ifid = w;
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (redir) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
      if (!stall_if) bubble();
    end
    if (flush_if) bubble();
  endfunction

  task automatic compare_all();
    logic exp_req;
    exp_req = !m_booting && (m_skid.size() == 0);
    check("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    check("imem_addr", imem_addr, m_pc);
    check("pc_o", pc_o, m_pc);
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_ifid.valid});
    check("ifid_instr", ifid_instr, m_ifid.instr);
    if (m_ifid.valid) check("ifid_pc_plus4", ifid_pc_plus4, m_ifid.pc4);
  endtask

  // Apply inputs for one clock (called just after a falling edge), advance
  // the model, and compare at the following falling edge.
  task automatic cycle(input bit rdy, input logic [31:0] rdata, input bit stl,
                       input bit fl, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt);
    imem_ready    = rdy;
    imem_rdata    = rdata;
    stall_if      = stl;
    flush_if      = fl;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit rdy, input logic [31:0] rdata);
    cycle(rdy, rdata, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0; imem_rdata = '0; stall_if = 1'b0; flush_if = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1. Boot from RESET_PC, back-to-back fetches.
    compare_all();
    check("boot_req", {31'h0, imem_req}, 32'h0);
    idle(1'b1, 32'h1111_0000);
    check("first_addr", imem_addr, 32'h100);
    idle(1'b1, 32'h1111_0100);
    check("addr_104", imem_addr, 32'h104);
    check("ifid_pc4_104", ifid_pc_plus4, 32'h104);
    check("ifid_instr_100", ifid_instr, 32'h1111_0100);

    // 2. Three wait states at 0x104.
    repeat (3) begin
      idle(1'b0, $urandom);
      check("wait_addr", imem_addr, 32'h104);
      check("wait_valid", {31'h0, ifid_valid}, 32'h0);
    end
    idle(1'b1, 32'h2222_0104);
    check("after_wait", ifid_instr, 32'h2222_0104);

    // 3. Stall during accept of 0x108, held for two cycles.
    cycle(1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("buf_req", {31'h0, imem_req}, 32'h0);
    check("buf_hold", ifid_instr, 32'h2222_0104);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1'b0, $urandom);
    check("skid_instr", ifid_instr, 32'hAAAA_0001);
    check("skid_pc4", ifid_pc_plus4, 32'h10C);
    check("next_fetch", imem_addr, 32'h10C);
    idle(1'b1, 32'h3333_010C);

    // 4. Branch and jump together while waiting on 0x110.
    cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
    check("redir_hold", imem_addr, 32'h110);
    idle(1'b0, $urandom);
    check("redir_hold2", imem_addr, 32'h110);
    idle(1'b1, 32'hBAD0_0110);
    check("redir_addr", imem_addr, 32'h200);
    check("redir_drop", {31'h0, ifid_valid}, 32'h0);
    idle(1'b1, 32'h4444_0200);
    check("redir_land", ifid_pc_plus4, 32'h204);

    // 5. Flush overrides stall with a valid IF/ID.
    cycle(1'b1, 32'h5555_0204, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("flush_valid", {31'h0, ifid_valid}, 32'h0);
    check("flush_instr", ifid_instr, 32'h0);
    idle(1'b1, $urandom);

    // 6. Asynchronous reset between clock edges during a wait.
    idle(1'b0, $urandom);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'h0, imem_req}, 32'h0);
    check("arst_pc", pc_o, RESET_PC);
    check("arst_valid", {31'h0, ifid_valid}, 32'h0);
    check("arst_instr", ifid_instr, 32'h0);
    check("arst_pc4", ifid_pc_plus4, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    idle(1'b1, $urandom);
    check("restart_addr", imem_addr, RESET_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 70, $urandom,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 10, $urandom,
            $urandom_range(0, 99) < 10, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
